ms_serial_mouse_rx: RTL and testbench

//  Host-side receiver for the Microsoft serial mouse protocol: 1200 baud, 7N1, LSB first, idle high.

---
 rtl/ms_serial_mouse_rx.sv | 190 +++++++++++++++++++
 tb/tb_ms_serial_mouse_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_serial_mouse_rx.sv
// Microsoft serial mouse host receiver: RTS reset/ident sequencing, 1200 7N1
// deserialiser and 3-byte packet assembly into signed dx/dy and button state.
module ms_serial_mouse_rx #(
    parameter int unsigned CLKFREQ    = 50_000_000,
    parameter int unsigned BAUD       = 1_200,
    parameter int unsigned RTS_LOW_MS = 100,
    parameter int unsigned IDENT_MS   = 250,
    parameter int unsigned GAP_MS     = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rescan,
    output logic       rts,
    output logic       pkt_valid,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] btn,
    output logic       present,
    output logic       frame_err
);

    localparam int unsigned BP     = CLKFREQ / BAUD;
    localparam int unsigned MS_CYC = CLKFREQ / 1000;
    localparam logic [31:0] BIT_LAST   = 32'(BP - 1);
    localparam logic [31:0] HALF_LAST  = 32'(BP / 2 - 1);
    localparam logic [31:0] RTS_LAST   = 32'(RTS_LOW_MS * MS_CYC - 1);
    localparam logic [31:0] IDENT_LAST = 32'(IDENT_MS * MS_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_MS * MS_CYC - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_WAIT} bstate_t;
    typedef enum logic [1:0] {C_RTS_LOW, C_IDENT, C_RUN} cstate_t;

    bstate_t     bstate_q, bstate_d;
    cstate_t     cstate_q, cstate_d;
    logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [31:0] bcnt_q;
    logic [2:0]  bidx_q;
    logic [6:0]  shreg_q;
    logic [31:0] tmr_q;
    logic [1:0]  idx_q;
    logic [5:0]  b1_q, b2_q;
    logic [7:0]  dx_q, dy_q;
    logic [1:0]  btn_q;
    logic        present_q, pkt_valid_q, frame_err_q;
    logic        fall, bit_tick, byte_done, ferr, process_byte, gap_exp, ident_to;

    assign fall     = rxd_prev_q & ~rxd_s2_q;
    assign bit_tick = (bstate_q == B_START) ? (bcnt_q == HALF_LAST) : (bcnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bstate_q <= B_IDLE;
        else        bstate_q <= bstate_d;
    end

    always_comb begin
        bstate_d = bstate_q;
        if (rescan) begin
            bstate_d = B_IDLE;
        end else begin
            case (bstate_q)
                B_IDLE:  if (fall) bstate_d = B_START;
                B_START: if (bit_tick) bstate_d = rxd_s2_q ? B_IDLE : B_DATA;
                B_DATA:  if (bit_tick && bidx_q == 3'd6) bstate_d = B_STOP;
                B_STOP:  if (bit_tick) bstate_d = rxd_s2_q ? B_IDLE : B_WAIT;
                B_WAIT:  if (rxd_s2_q) bstate_d = B_IDLE;
                default: bstate_d = B_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_done = 1'b0;
        ferr      = 1'b0;
        if (!rescan && bstate_q == B_STOP && bit_tick) begin
            byte_done = rxd_s2_q;
            ferr      = ~rxd_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
        end else begin
            if (rescan || bstate_q == B_IDLE || bstate_q == B_WAIT || bit_tick) bcnt_q <= '0;
            else bcnt_q <= bcnt_q + 32'd1;
            if (bstate_q == B_START) begin
                bidx_q <= '0;
            end else if (bstate_q == B_DATA && bit_tick) begin
                bidx_q  <= bidx_q + 3'd1;
                shreg_q <= {rxd_s2_q, shreg_q[6:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cstate_q <= C_RTS_LOW;
        else        cstate_q <= cstate_d;
    end

    assign ident_to = (cstate_q == C_IDENT) && (tmr_q == IDENT_LAST);

    always_comb begin
        cstate_d = cstate_q;
        if (rescan) begin
            cstate_d = C_RTS_LOW;
        end else begin
            case (cstate_q)
                C_RTS_LOW: if (tmr_q == RTS_LAST) cstate_d = C_IDENT;
                C_IDENT:   if (byte_done || ident_to) cstate_d = C_RUN;
                default:   cstate_d = C_RUN;
            endcase
        end
    end

    always_comb begin
        rts = (cstate_q != C_RTS_LOW);
    end

    // A non-'M' first byte in the ident window is treated as ordinary traffic.
    assign process_byte = byte_done &&
        ((cstate_q == C_RUN) || (cstate_q == C_IDENT && shreg_q != 7'h4D));
    assign gap_exp = (cstate_q == C_RUN) && (tmr_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q       <= '0;
            present_q   <= 1'b0;
            idx_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            btn_q       <= '0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            pkt_valid_q <= 1'b0;
            frame_err_q <= ferr;
            if (rescan || byte_done || cstate_d != cstate_q) tmr_q <= '0;
            else if (tmr_q != '1) tmr_q <= tmr_q + 32'd1;

            if (rescan) present_q <= 1'b0;
            else if (cstate_q == C_IDENT && byte_done && shreg_q == 7'h4D) present_q <= 1'b1;
            else if (ident_to && !byte_done) present_q <= 1'b0;

            if (rescan) begin
                idx_q <= '0;
            end else if (process_byte) begin
                if (shreg_q[6]) begin
                    b1_q  <= shreg_q[5:0];
                    idx_q <= 2'd1;
                end else if (idx_q == 2'd1) begin
                    b2_q  <= shreg_q[5:0];
                    idx_q <= 2'd2;
                end else if (idx_q == 2'd2) begin
                    btn_q       <= {b1_q[4], b1_q[5]};
                    dx_q        <= {b1_q[1:0], b2_q};
                    dy_q        <= {b1_q[3:2], shreg_q[5:0]};
                    pkt_valid_q <= 1'b1;
                    idx_q       <= 2'd0;
                end
            end else if (gap_exp) begin
                idx_q <= 2'd0;
            end
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign btn       = btn_q;
    assign present   = present_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ms_serial_mouse_rx.sv
// Directed bench for ms_serial_mouse_rx with a scaled-down clock so the
// RTS/ident/gap timing fits a short simulation.
module tb_ms_serial_mouse_rx;

    localparam int unsigned CLKFREQ   = 120_000;
    localparam int unsigned BAUD      = 1_200;
    localparam int unsigned BP        = 100;
    localparam int unsigned MS_CYC    = 120;
    localparam int unsigned RTS_CYC   = 20 * MS_CYC;
    localparam int unsigned IDENT_CYC = 40 * MS_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rescan = 1'b0;
    logic       rts, pkt_valid, present, frame_err;
    logic [7:0] dx, dy;
    logic [1:0] btn;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;
    int fe_cnt   = 0;
    int pv0, fe0;

    ms_serial_mouse_rx #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .RTS_LOW_MS(20),
        .IDENT_MS  (40),
        .GAP_MS    (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rescan   (rescan),
        .rts      (rts),
        .pkt_valid(pkt_valid),
        .dx       (dx),
        .dy       (dy),
        .btn      (btn),
        .present  (present),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Strobe cycles are counted, so a strobe stuck high shows up as extra counts.
    always @(posedge clk) begin
        #1;
        if (pkt_valid === 1'b1) pv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [6:0] b, input logic stop, input int unsigned idle);
        rxd = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rxd = b[i];
            repeat (BP) @(negedge clk);
        end
        rxd = stop;
        repeat (BP) @(negedge clk);
        rxd = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic wait_rts_high(input string name);
        for (int i = 0; i < int'(RTS_CYC) + 20 && rts !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (rts !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rts=%b required 1 within timeout", name, rts);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rts, pkt_valid, present, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {rts,pv,present,ferr}=%b required 0000",
                     {rts, pkt_valid, present, frame_err});
        end
        n_checks++;
        if ({dx, dy, btn} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_data: dx=%h dy=%h btn=%b required 00 00 00", dx, dy, btn);
        end
        rst_n = 1'b1;
        repeat (RTS_CYC - 1) @(posedge clk);
        #1;
        n_checks++;
        if (rts !== 1'b0) begin
            n_fail++;
            $display("FAIL rts_low_time: rts=%b required 0 one cycle before expiry", rts);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rts !== 1'b1) begin
            n_fail++;
            $display("FAIL rts_rise: rts=%b required 1 at RTS_LOW_MS", rts);
        end
        @(negedge clk);
    endtask

    task automatic test_ident_timeout;
        repeat (IDENT_CYC + 20) @(negedge clk);
        n_checks++;
        if (present !== 1'b0) begin
            n_fail++;
            $display("FAIL ident_timeout: present=%b required 0", present);
        end
        n_checks++;
        if (pv_cnt != 0 || fe_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_strobes: pv=%0d fe=%0d required 0 0", pv_cnt, fe_cnt);
        end
    endtask

    task automatic test_ident_m;
        rescan = 1'b1;
        @(negedge clk);
        rescan = 1'b0;
        n_checks++;
        if (rts !== 1'b0) begin
            n_fail++;
            $display("FAIL rescan_rts: rts=%b required 0", rts);
        end
        wait_rts_high("ident_rts");
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(7'h4D, 1'b1, BP);
        n_checks++;
        if (present !== 1'b1) begin
            n_fail++;
            $display("FAIL ident_m: present=%b required 1", present);
        end
        send_byte(7'h33, 1'b1, BP);
        n_checks++;
        if (present !== 1'b1 || pv_cnt != pv0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL ident_33: present=%b pv+%0d fe+%0d required 1 +0 +0",
                     present, pv_cnt - pv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_packets;
        pv0 = pv_cnt;
        send_byte(7'h6C, 1'b1, BP);
        send_byte(7'h05, 1'b1, BP);
        send_byte(7'h3F, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 + 1 || btn !== 2'b01 || dx !== 8'h05 || dy !== 8'hFF) begin
            n_fail++;
            $display("FAIL pkt_left: pv+%0d btn=%b dx=%h dy=%h required +1 01 05 ff",
                     pv_cnt - pv0, btn, dx, dy);
        end
        pv0 = pv_cnt;
        send_byte(7'h43, 1'b1, BP);
        send_byte(7'h3F, 1'b1, BP);
        send_byte(7'h00, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 + 1 || btn !== 2'b00 || dx !== 8'hFF || dy !== 8'h00) begin
            n_fail++;
            $display("FAIL pkt_negx: pv+%0d btn=%b dx=%h dy=%h required +1 00 ff 00",
                     pv_cnt - pv0, btn, dx, dy);
        end
    endtask

    task automatic test_resync;
        pv0 = pv_cnt;
        send_byte(7'h50, 1'b1, BP);
        send_byte(7'h01, 1'b1, BP);
        send_byte(7'h40, 1'b1, BP);
        send_byte(7'h02, 1'b1, BP);
        send_byte(7'h03, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 + 1 || btn !== 2'b00 || dx !== 8'h02 || dy !== 8'h03) begin
            n_fail++;
            $display("FAIL resync: pv+%0d btn=%b dx=%h dy=%h required +1 00 02 03",
                     pv_cnt - pv0, btn, dx, dy);
        end
    endtask

    task automatic test_frame_err;
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(7'h40, 1'b0, BP);
        n_checks++;
        if (fe_cnt != fe0 + 1) begin
            n_fail++;
            $display("FAIL frame_err_pulse: fe+%0d required +1", fe_cnt - fe0);
        end
        send_byte(7'h05, 1'b1, BP);
        send_byte(7'h06, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 || fe_cnt != fe0 + 1 || dx !== 8'h02) begin
            n_fail++;
            $display("FAIL frame_err_drop: pv+%0d fe+%0d dx=%h required +0 +1 02",
                     pv_cnt - pv0, fe_cnt - fe0, dx);
        end
    endtask

    task automatic test_gap;
        pv0 = pv_cnt;
        send_byte(7'h40, 1'b1, BP);
        send_byte(7'h01, 1'b1, 15 * MS_CYC);
        send_byte(7'h02, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 || dx !== 8'h02 || dy !== 8'h03) begin
            n_fail++;
            $display("FAIL gap_resync: pv+%0d dx=%h dy=%h required +0 02 03",
                     pv_cnt - pv0, dx, dy);
        end
    endtask

    task automatic test_glitch;
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BP) @(negedge clk);
        send_byte(7'h01, 1'b1, BP);
        send_byte(7'h02, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL glitch: pv+%0d fe+%0d required +0 +0", pv_cnt - pv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_rescan_midbyte;
        logic [6:0] b;
        b   = 7'h02;
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(7'h40, 1'b1, BP);
        send_byte(7'h01, 1'b1, BP);
        rxd = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            repeat (BP) @(negedge clk);
        end
        rescan = 1'b1;
        @(negedge clk);
        rescan = 1'b0;
        n_checks++;
        if (rts !== 1'b0 || present !== 1'b0) begin
            n_fail++;
            $display("FAIL rescan_mid: rts=%b present=%b required 0 0", rts, present);
        end
        for (int i = 3; i < 7; i++) begin
            rxd = b[i];
            repeat (BP) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (2 * BP) @(negedge clk);
        n_checks++;
        if (pv_cnt != pv0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL rescan_partial: pv+%0d fe+%0d required +0 +0",
                     pv_cnt - pv0, fe_cnt - fe0);
        end
        wait_rts_high("rescan_rts");
        send_byte(7'h4C, 1'b1, BP);
        send_byte(7'h0A, 1'b1, BP);
        send_byte(7'h01, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 + 1 || btn !== 2'b00 || dx !== 8'h0A || dy !== 8'hC1 || present !== 1'b0) begin
            n_fail++;
            $display("FAIL ident_nonm: pv+%0d btn=%b dx=%h dy=%h present=%b required +1 00 0a c1 0",
                     pv_cnt - pv0, btn, dx, dy, present);
        end
    endtask

    task automatic test_back_to_back;
        pv0 = pv_cnt;
        send_byte(7'h70, 1'b1, 0);
        send_byte(7'h01, 1'b1, 0);
        send_byte(7'h02, 1'b1, 0);
        n_checks++;
        if (pv_cnt != pv0 + 1 || btn !== 2'b11 || dx !== 8'h01 || dy !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_first: pv+%0d btn=%b dx=%h dy=%h required +1 11 01 02",
                     pv_cnt - pv0, btn, dx, dy);
        end
        send_byte(7'h4A, 1'b1, 0);
        send_byte(7'h00, 1'b1, 0);
        send_byte(7'h3F, 1'b1, BP);
        n_checks++;
        if (pv_cnt != pv0 + 2 || btn !== 2'b00 || dx !== 8'h80 || dy !== 8'hBF) begin
            n_fail++;
            $display("FAIL b2b_second: pv+%0d btn=%b dx=%h dy=%h required +2 00 80 bf",
                     pv_cnt - pv0, btn, dx, dy);
        end
    endtask

    initial begin
        test_reset;
        test_ident_timeout;
        test_ident_m;
        test_packets;
        test_resync;
        test_frame_err;
        test_gap;
        test_glitch;
        test_rescan_midbyte;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
